seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexes one shared LEDdecoder across a 4-digit common-anode 7-segment display.
- Each scan phase selects one nibble of a 16-bit display word and drives it onto the decoder's char input, then enables the matching anode.
- A blanking interval separates digits to suppress ghosting.
- New display words are double-buffered and applied only at frame boundaries, so no frame is ever torn.

Parameters:
- PHASE_CYCLES, 16, total clock cycles per digit phase (blank + drive); must satisfy PHASE_CYCLES > BLANK_CYCLES.
- BLANK_CYCLES, 2, cycles at the start of each phase with all anodes off; must be >= 1.
- CNT_W, 16, width of the phase counter; must satisfy 2^CNT_W > PHASE_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; low forces idle with display dark.
- load  in  1  one-cycle strobe; captures digits_in into the pending buffer.
- digits_in  in  16  display word; [15:12]=leftmost digit (an[3]) ... [3:0]=rightmost (an[0]).
- char  out  4  nibble to LEDdecoder.char, registered.
- an  out  4  anode enables, active-low, registered; at most one bit low at any time.
- frame_done  out  1  one-cycle pulse on the last drive cycle of digit 0.
- pending  out  1  high while a loaded word awaits the frame boundary.

Behaviour:
- Reset (reset=0, async):
  - Outputs: an=4'b1111, char=4'h0, frame_done=0, pending=0.
  - Internal: active word=16'h0000, pending word=16'h0000, state=IDLE, digit index=3, counter=0.
- States are IDLE, BLANK, DRIVE.
- IDLE:
  - an=1111, char=0.
  - If enable=1, next cycle goes to BLANK with digit index=3 and counter=0.
- BLANK:
  - an=1111; char=active[4*idx+3 : 4*idx], set on BLANK entry so the decoder settles before the anode turns on.
  - Lasts BLANK_CYCLES cycles, then goes to DRIVE.
- DRIVE:
  - an[idx]=0, all other anode bits 1; char unchanged.
  - Lasts PHASE_CYCLES-BLANK_CYCLES cycles.
  - At the end: if idx>0, idx decrements and state goes to BLANK. If idx=0, that cycle is the frame boundary: frame_done=1, idx wraps to 3, state goes to BLANK.
- Scan order is 3,2,1,0,3,... One frame = 4*PHASE_CYCLES cycles. The counter counts 0..PHASE_CYCLES-1 per phase and wraps to 0.
- Load / buffer rules:
  - load=1 captures digits_in into the pending word and sets pending=1 on the next edge.
  - load while pending=1 overwrites the pending word (last write wins).
  - At the frame boundary, if pending=1: active<=pending word, pending<=0. The next frame's digit 3 shows the new word.
  - load on the boundary cycle itself: digits_in goes directly to active and pending is cleared. This takes priority over the older pending word.
  - With enable=0, load still updates the pending word. On the IDLE->BLANK transition, any pending word is transferred to active first, so startup never shows a stale word.
- enable deasserted mid-frame:
  - Next cycle: state=IDLE, an=1111, char=0, counter=0, idx=3, frame_done=0. The partial frame is abandoned; pending is kept.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and an goes to 1111 without waiting for a clock.
- Invariants (synthesisable assertions optional):
  - an never has two bits low at once.
  - an is never low during BLANK.
  - char is never changed while any anode bit is low.

Test Plan (PHASE_CYCLES=16, BLANK_CYCLES=2):
- Reset/startup:
  - Stimulus: hold reset=0 for 5 cycles with enable=1; then load digits_in=16'h1234 while still in reset-release IDLE, release reset.
  - Required response: an=1111 and char=0 during reset. First BLANK shows char=1 with an=1111 for 2 cycles, then an=0111 for 14 cycles. Then char=2/an=1011, 3/1101, 4/1110. frame_done pulses at cycle 64 of the scan.
- Double buffering:
  - Stimulus: load 16'hABCD mid-frame (during digit 2).
  - Required response: pending=1 and current frame completes showing 1,2,3,4. Next frame shows A,B,C,D. pending drops on the boundary cycle.
- Last-write-wins and boundary collision:
  - Stimulus: load 16'h1111 then 16'h2222 mid-frame; next frame, load 16'h5A5A exactly on the frame_done cycle.
  - Required response: the frame after the first two loads shows 2,2,2,2. The 5A5A word appears in the following frame with pending=0.
- Enable drop:
  - Stimulus: deassert enable during DRIVE of digit 1, reassert after 10 cycles.
  - Required response: an=1111 and char=0 the cycle after the drop. Scan restarts at digit 3 BLANK, and no frame_done is issued for the aborted frame.
- Async reset mid-DRIVE:
  - Stimulus: pulse reset low between clock edges during digit 2 drive.
  - Required response: an=1111 immediately; active word is 0000, so the display shows 0,0,0,0 after release.
- Full hex sweep:
  - Stimulus: load each of 16'h0000, 16'h1111 ... 16'hFFFF across 16 frames.
  - Required response: char matches each nibble per frame, and the one-hot-low anode invariant holds on every cycle.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display sharing one LEDdecoder.
// Digits are scanned 3..0, each phase blank then drive; new words land only at frame boundaries.
module seg_scan_ctrl #(
    parameter int PHASE_CYCLES = 16,
    parameter int BLANK_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] digits_in,
    output logic [3:0]  char,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        pending
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);

    logic [1:0]       state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [1:0]       idx, nxt_idx;
    logic [15:0]      active, pend_word, new_active;
    logic             xfer;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = idx;
        if (!enable) begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
            nxt_idx   = 2'd3;
        end else begin
            case (state)
                S_IDLE: begin
                    nxt_state = S_BLANK;
                    nxt_cnt   = '0;
                    nxt_idx   = 2'd3;
                end
                S_BLANK: begin
                    nxt_cnt = cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) nxt_state = S_DRIVE;
                end
                S_DRIVE: begin
                    if (cnt == PHASE_LAST) begin
                        nxt_state = S_BLANK;
                        nxt_cnt   = '0;
                        nxt_idx   = idx - 2'd1;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                    nxt_idx   = 2'd3;
                end
            endcase
        end
    end

    // Active word only changes at a frame boundary or at scan start; a load on
    // that same cycle bypasses the pending buffer.
    always_comb begin
        xfer       = frame_done || (state == S_IDLE && enable);
        new_active = active;
        if (xfer) new_active = load ? digits_in : (pending ? pend_word : active);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= 2'd3;
            active     <= '0;
            pend_word  <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= 4'hF;
            char       <= 4'h0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            idx    <= nxt_idx;
            active <= new_active;
            if (xfer) begin
                pending <= 1'b0;
            end else if (load) begin
                pend_word <= digits_in;
                pending   <= 1'b1;
            end
            frame_done <= (nxt_state == S_DRIVE) && (nxt_idx == 2'd0) && (nxt_cnt == PHASE_LAST);
            an         <= (nxt_state == S_DRIVE) ? ~(4'b0001 << nxt_idx) : 4'hF;
            // char moves only on BLANK entry, while every anode is off
            if (nxt_state == S_IDLE)
                char <= 4'h0;
            else if (nxt_state == S_BLANK && nxt_cnt == '0)
                char <= new_active[{nxt_idx, 2'b00} +: 4];
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: frame-by-frame scan checks with buffered loads,
// enable drop, async reset and a hex sweep.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  char;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(.PHASE_CYCLES(16), .BLANK_CYCLES(2), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .char       (char),
        .an         (an),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Walks one 64-cycle frame showing word w; optional loads at cycle indices la1/la2;
    // returns early after sampling cycle stop_at.
    task automatic run_frame(input logic [15:0] w, input logic pin,
                             input int la1, input logic [15:0] v1,
                             input int la2, input logic [15:0] v2,
                             input int stop_at);
        logic       pe;
        logic [3:0] ean, ech;
        int         d, c;
        pe = pin;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            d   = 3 - k / 16;
            c   = k % 16;
            ech = w[4*d +: 4];
            ean = (c < 2) ? 4'hF : ~(4'b0001 << d);
            chk("an",   32'(an),   32'(ean));
            chk("char", 32'(char), 32'(ech));
            chk("fdone", 32'(frame_done), 32'(k == 63));
            chk("pend", 32'(pending), 32'(pe));
            chk("an_1hot", 32'($countones(~an) <= 1), 32'd1);
            if (k == stop_at) return;
            load      = (k == la1) || (k == la2);
            digits_in = (k == la2) ? v2 : v1;
            if (load && k < 63) pe = 1'b1;
        end
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0000;

        repeat (5) @(negedge clk);
        chk("rst_an",   32'(an),   32'hF);
        chk("rst_char", 32'(char), 32'h0);
        chk("rst_fd",   32'(frame_done), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);

        // release with a load on the IDLE->BLANK cycle
        reset     = 1'b1;
        load      = 1'b1;
        digits_in = 16'h1234;
        run_frame(16'h1234, 1'b0, -1, 16'h0, -1, 16'h0, 99);

        // double buffering: load during digit 2
        run_frame(16'h1234, 1'b0, 20, 16'hABCD, -1, 16'h0, 99);
        // last write wins
        run_frame(16'hABCD, 1'b0, 10, 16'h1111, 30, 16'h2222, 99);
        // load on the boundary cycle
        run_frame(16'h2222, 1'b0, 63, 16'h5A5A, -1, 16'h0, 99);
        run_frame(16'h5A5A, 1'b0, -1, 16'h0, -1, 16'h0, 99);

        // enable drop during digit 1 drive
        run_frame(16'h5A5A, 1'b0, -1, 16'h0, -1, 16'h0, 39);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("off_an",   32'(an),   32'hF);
            chk("off_char", 32'(char), 32'h0);
            chk("off_fd",   32'(frame_done), 32'd0);
        end
        enable = 1'b1;
        run_frame(16'h5A5A, 1'b0, -1, 16'h0, -1, 16'h0, 99);

        // async reset pulse mid digit-2 drive
        run_frame(16'h5A5A, 1'b0, -1, 16'h0, -1, 16'h0, 25);
        #2 reset = 1'b0;
        #1;
        chk("arst_an",   32'(an),   32'hF);
        chk("arst_char", 32'(char), 32'h0);
        chk("arst_fd",   32'(frame_done), 32'd0);
        chk("arst_pend", 32'(pending), 32'd0);
        #1 reset = 1'b1;

        // hex sweep: frame i shows (i-1)*1111 and loads i*1111 for the next one
        for (int i = 0; i <= 16; i++) begin
            logic [15:0] cur, nxt;
            cur = (i == 0) ? 16'h0000 : 16'((i - 1) * 16'h1111);
            nxt = 16'(i * 16'h1111);
            if (i < 16) run_frame(cur, 1'b0, 10, nxt, -1, 16'h0, 99);
            else        run_frame(cur, 1'b0, -1, 16'h0, -1, 16'h0, 99);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
